// File: rtl/sccb_init_seq.sv
// SCCB init sequencer: walks a synchronous command ROM of register writes,
// read-verifies and delays, driving the controller handshake with retry and watchdog.
module sccb_init_seq #(
  parameter logic [7:0]  DEV_ID    = 8'h78,
  parameter int unsigned ROM_AW    = 10,
  parameter int unsigned MAX_RETRY = 3,
  parameter int unsigned DLY_UNIT  = 50000,
  parameter int unsigned TIMEOUT   = 2000000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              init_start_i,
  output logic [ROM_AW-1:0] rom_addr_o,
  input  logic [31:0]       rom_data_i,
  output logic [7:0]        sccb_addr_o,
  output logic [23:0]       sccb_data_o,
  output logic              sccb_rw_o,
  output logic              sccb_start_o,
  input  logic              sccb_done_i,
  input  logic              sccb_ack_err_i,
  input  logic [7:0]        sccb_rdata_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o,
  output logic [ROM_AW-1:0] err_index_o
);

  localparam longint unsigned TMR_MAX = 64'd65535 * 64'(DLY_UNIT);
  localparam int unsigned TW = $clog2(TMR_MAX + 1);
  localparam int unsigned WW = $clog2(64'(TIMEOUT) + 1);
  localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, ISSUE, WAIT, RELEASE, DELAY, NEXT, FIN, FAIL
  } state_t;

  typedef enum logic [1:0] {
    OP_WRITE  = 2'b00,
    OP_DELAY  = 2'b01,
    OP_VERIFY = 2'b10,
    OP_END    = 2'b11
  } op_t;

  state_t            state, nxt;
  op_t               op;
  logic              init_q;
  logic              start_edge;
  logic [ROM_AW-1:0] index;
  logic [RW-1:0]     retry;
  logic [TW-1:0]     timer;
  logic [WW-1:0]     wdog;
  logic [7:0]        expected;
  logic              is_verify;
  logic              fail_q;
  logic              fail_now;
  logic              wdog_exp;
  logic              retry_left;
  logic [15:0]       dly_count;
  logic              rom_unused;

  assign op         = op_t'(rom_data_i[31:30]);
  assign dly_count  = rom_data_i[15:0];
  assign rom_unused = ^rom_data_i[29:24];
  assign start_edge = init_start_i && !init_q;
  assign wdog_exp   = (wdog == WW'(TIMEOUT - 1));
  assign retry_left = (retry < RW'(MAX_RETRY));
  // ack and read-back are only meaningful in the cycle done is seen
  assign fail_now   = sccb_ack_err_i || (is_verify && (sccb_rdata_i != expected));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (start_edge) nxt = FETCH;
      FETCH:   nxt = DECODE;
      DECODE: begin
        case (op)
          OP_END:   nxt = FIN;
          OP_DELAY: nxt = (dly_count == 16'd0) ? NEXT : DELAY;
          default:  nxt = ISSUE;
        endcase
      end
      ISSUE:   nxt = WAIT;
      WAIT:    if (sccb_done_i || wdog_exp) nxt = RELEASE;
      RELEASE: begin
        if (!sccb_done_i) begin
          if (!fail_q)         nxt = NEXT;
          else if (retry_left) nxt = ISSUE;
          else                 nxt = FAIL;
        end else if (wdog_exp) begin
          nxt = FAIL;
        end
      end
      DELAY:   if (timer == '0) nxt = NEXT;
      NEXT:    nxt = (index == '1) ? FAIL : FETCH;
      FIN:     nxt = IDLE;
      FAIL:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    sccb_start_o = (state == ISSUE) || (state == WAIT);
    sccb_addr_o  = DEV_ID;
    rom_addr_o   = index;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      init_q      <= 1'b0;
      index       <= '0;
      retry       <= '0;
      timer       <= '0;
      wdog        <= '0;
      expected    <= '0;
      is_verify   <= 1'b0;
      fail_q      <= 1'b0;
      sccb_data_o <= '0;
      sccb_rw_o   <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      error_o     <= 1'b0;
      err_index_o <= '0;
    end else begin
      init_q <= init_start_i;
      case (state)
        IDLE: begin
          if (start_edge) begin
            index   <= '0;
            retry   <= '0;
            done_o  <= 1'b0;
            error_o <= 1'b0;
            busy_o  <= 1'b1;
          end
        end
        DECODE: begin
          if (op == OP_DELAY)
            timer <= TW'(64'(dly_count) * 64'(DLY_UNIT) - 64'd1);
          if (op == OP_WRITE || op == OP_VERIFY) begin
            sccb_data_o <= rom_data_i[23:0];
            sccb_rw_o   <= (op == OP_WRITE);
            is_verify   <= (op == OP_VERIFY);
            expected    <= rom_data_i[7:0];
          end
        end
        ISSUE: begin
          wdog   <= '0;
          fail_q <= 1'b0;
        end
        WAIT: begin
          if (sccb_done_i)   fail_q <= fail_now;
          else if (wdog_exp) fail_q <= 1'b1;
          else               wdog   <= wdog + 1'b1;
        end
        RELEASE: begin
          // the watchdog keeps running while waiting for done to fall
          if (!sccb_done_i) begin
            if (fail_q && retry_left) retry <= retry + 1'b1;
          end else if (!wdog_exp) begin
            wdog <= wdog + 1'b1;
          end
        end
        DELAY: begin
          if (timer != '0) timer <= timer - 1'b1;
        end
        NEXT: begin
          if (index != '1) begin
            index <= index + 1'b1;
            retry <= '0;
          end
        end
        FIN: begin
          busy_o <= 1'b0;
          done_o <= 1'b1;
        end
        FAIL: begin
          busy_o      <= 1'b0;
          error_o     <= 1'b1;
          err_index_o <= index;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sccb_init_seq.sv
// Bench for sccb_init_seq: directed vector table plus randomized ROM programs,
// checked against a transaction-level model of pulses, gaps and final status.
module tb_sccb_init_seq;
  localparam int AW   = 4;
  localparam int MAXR = 3;
  localparam int DLY  = 10;
  localparam int TO   = 100;
  localparam int NP   = 64;
  localparam logic [31:0] END_W = 32'hC000_0000;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          init = 1'b0;
  logic [AW-1:0] rom_addr;
  logic [31:0]   rom_data;
  logic [7:0]    sccb_addr;
  logic [23:0]   sccb_data;
  logic          sccb_rw, sccb_start;
  logic          sccb_done = 1'b0;
  logic          sccb_ack_err = 1'b0;
  logic [7:0]    sccb_rdata = '0;
  logic          busy, done, error;
  logic [AW-1:0] err_index;

  always #5 clk = ~clk;

  sccb_init_seq #(.DEV_ID(8'h78), .ROM_AW(AW), .MAX_RETRY(MAXR), .DLY_UNIT(DLY), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst), .init_start_i(init),
    .rom_addr_o(rom_addr), .rom_data_i(rom_data),
    .sccb_addr_o(sccb_addr), .sccb_data_o(sccb_data), .sccb_rw_o(sccb_rw),
    .sccb_start_o(sccb_start), .sccb_done_i(sccb_done), .sccb_ack_err_i(sccb_ack_err),
    .sccb_rdata_i(sccb_rdata), .busy_o(busy), .done_o(done), .error_o(error),
    .err_index_o(err_index)
  );

  logic [31:0] rom_mem [16];
  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  // per-attempt slave behaviour, indexed by global start-pulse number
  bit          s_ack  [NP];
  bit          s_hang [NP];
  logic [7:0]  s_rd   [NP];
  // expected transaction trace
  logic [23:0] e_data [NP];
  bit          e_rw   [NP];
  int          e_hi   [NP];
  int          e_lo   [NP];
  int          e_n, e_eidx;
  bit          e_done, e_err;

  int    checks = 0;
  int    errors = 0;
  string tag = "";

  typedef struct packed {
    logic [15:0][31:0] rom;
    logic [15:0]       ack;
    logic [15:0]       hang;
    logic [7:0]        rd;
    logic [3:0]        lat;
    logic [3:0]        hold;
    logic [7:0]        n;
    logic              done;
    logic              err;
    logic [3:0]        eidx;
  } vec_t;

  vec_t vt [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s/%s: got %0h expected %0h", tag, nm, act, exp);
    end
  endtask

  function automatic logic [31:0] wr(input logic [15:0] r, input logic [7:0] d);
    return {2'b00, 6'b0, r, d};
  endfunction
  function automatic logic [31:0] vf(input logic [15:0] r, input logic [7:0] d);
    return {2'b10, 6'b0, r, d};
  endfunction
  function automatic logic [31:0] dl(input logic [15:0] c);
    return {2'b01, 14'b0, c};
  endfunction

  // Walks the ROM entry by entry: each attempt is one start pulse; gaps are
  // RELEASE (+hold) plus NEXT/FETCH/DECODE per entry and the delay units.
  task automatic model(input int lat, input int hold);
    int idx, p, gap, tail;
    bit ok, fin;
    logic [31:0] w;
    idx = 0; p = 0; gap = 0; tail = 0; fin = 0;
    e_done = 0; e_err = 0; e_eidx = 0;
    while (!fin) begin
      if (idx == 16) begin
        e_err = 1; e_eidx = 15; fin = 1;
      end else begin
        w = rom_mem[idx];
        case (w[31:30])
          2'b11: begin e_done = 1; fin = 1; end
          2'b01: begin gap += 3 + int'(w[15:0]) * DLY; idx++; end
          default: begin
            ok = 0;
            for (int a = 0; a <= MAXR && !ok; a++) begin
              if (p > 0) e_lo[p-1] = gap;
              e_data[p] = w[23:0];
              e_rw[p]   = (w[31:30] == 2'b00);
              e_hi[p]   = s_hang[p] ? TO + 1 : (lat < 2 ? 2 : lat);
              ok   = !s_hang[p] && !s_ack[p] && (e_rw[p] || s_rd[p] == w[7:0]);
              tail = s_hang[p] ? 0 : hold;
              p++;
              gap = tail + 1;
            end
            if (!ok) begin e_err = 1; e_eidx = idx; fin = 1; end
            else begin gap = tail + 4; idx++; end
          end
        endcase
      end
    end
    e_n = p;
  endtask

  task automatic run_seq(input int lat, input int hold, input bit keep_high, output int pulses);
    int k, hi, lo, cyc, hcnt, hold_cnt;
    bit prev, seen_busy, finished, unstable, s, bad;
    logic [23:0] cur_data;
    logic cur_rw;
    k = 0; hi = 0; lo = 0; cyc = 0; hcnt = 0; hold_cnt = 0;
    prev = 0; seen_busy = 0; finished = 0; unstable = 0;
    cur_data = '0; cur_rw = 0;
    @(negedge clk);
    init = 1'b1;
    while (!finished && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (!keep_high) init = (cyc == 6);
      if (busy) seen_busy = 1;
      else if (seen_busy) finished = 1;
      s = sccb_start;
      if (s && !prev) begin
        if (k >= e_n) chk("extra_start", 32'(k), 32'(e_n));
        else begin
          if (k > 0) chk("gap", 32'(lo), 32'(e_lo[k-1]));
          chk("data", 32'(sccb_data), 32'(e_data[k]));
          chk("rw", 32'(sccb_rw), 32'(e_rw[k]));
          if (k == 0) chk("status_at_start", {29'd0, busy, done, error}, 32'h4);
        end
        hi = 0; cur_data = sccb_data; cur_rw = sccb_rw;
      end
      if (!s && prev) begin
        if (k < e_n) chk("high_len", 32'(hi), 32'(e_hi[k]));
        k++; lo = 0;
      end
      if (s) begin
        hi++;
        if (sccb_data !== cur_data || sccb_rw !== cur_rw) unstable = 1;
      end else lo++;
      prev = s;
      // controller model
      if (s) begin
        hcnt++;
        if (k < NP && !s_hang[k] && hcnt >= lat) begin
          sccb_done = 1'b1; sccb_ack_err = s_ack[k]; sccb_rdata = s_rd[k];
        end
      end else begin
        hcnt = 0;
        if (sccb_done) begin
          if (hold_cnt >= hold) begin sccb_done = 1'b0; hold_cnt = 0; end
          else hold_cnt++;
        end
      end
    end
    if (!keep_high) init = 1'b0;
    sccb_done = 1'b0; sccb_ack_err = 1'b0;
    chk("finished", 32'(finished), 32'd1);
    chk("pulses", 32'(k), 32'(e_n));
    chk("done", 32'(done), 32'(e_done));
    chk("error", 32'(error), 32'(e_err));
    if (e_err) chk("err_index", 32'(err_index), 32'(e_eidx));
    chk("stable", 32'(unstable), 32'd0);
    if (keep_high) begin
      bad = 0;
      repeat (10) begin @(negedge clk); if (busy || sccb_start) bad = 1; end
      chk("level_no_restart", 32'(bad), 32'd0);
      init = 1'b0;
    end
    pulses = k;
  endtask

  task automatic load_vec(input vec_t v);
    for (int i = 0; i < 16; i++) rom_mem[i] = v.rom[i];
    for (int p = 0; p < NP; p++) begin
      s_ack[p]  = (p < 16) ? v.ack[p]  : 1'b0;
      s_hang[p] = (p < 16) ? v.hang[p] : 1'b0;
      s_rd[p]   = v.rd;
    end
  endtask

  initial begin
    int np, bad, cnt;
    for (int i = 0; i < 10; i++) begin
      vt[i] = '0; vt[i].rom = '1; vt[i].lat = 4'd2;
    end
    vt[0].rom[0] = wr(16'h3008, 8'h82);  vt[0].n = 1; vt[0].done = 1;
    vt[1].rom[0] = wr(16'h3008, 8'h82);  vt[1].rom[1] = dl(16'd2);
    vt[1].rom[2] = wr(16'h3103, 8'h11);  vt[1].lat = 4'd1; vt[1].n = 2; vt[1].done = 1;
    vt[2].rom[0] = wr(16'h3008, 8'h82);  vt[2].ack = 16'h0003; vt[2].n = 3; vt[2].done = 1;
    vt[3].rom[0] = wr(16'h3008, 8'h02);  vt[3].rom[1] = wr(16'h3017, 8'h00);
    vt[3].ack = 16'h001E; vt[3].n = 5; vt[3].err = 1; vt[3].eidx = 4'd1;
    vt[4].rom[0] = vf(16'h300A, 8'h56);  vt[4].rd = 8'h56; vt[4].n = 1; vt[4].done = 1;
    vt[5].rom[0] = vf(16'h300A, 8'h56);  vt[5].rd = 8'h55; vt[5].n = 4; vt[5].err = 1;
    vt[6].rom[0] = wr(16'h3008, 8'h82);  vt[6].hang = 16'h000F; vt[6].n = 4; vt[6].err = 1;
    for (int i = 0; i < 16; i++) vt[7].rom[i] = wr(16'h3000 + 16'(i), 8'(i));
    vt[7].lat = 4'd3; vt[7].n = 16; vt[7].err = 1; vt[7].eidx = 4'd15;
    vt[8].rom[0] = dl(16'd0);  vt[8].rom[1] = wr(16'h3100, 8'hAA); vt[8].rom[2] = dl(16'd1);
    vt[8].ack = 16'h0001; vt[8].hold = 4'd3; vt[8].n = 2; vt[8].done = 1;
    vt[9].rom[0] = vf(16'h300A, 8'h56);  vt[9].rd = 8'h56; vt[9].ack = 16'h0001;
    vt[9].lat = 4'd5; vt[9].n = 2; vt[9].done = 1;

    tag = "reset";
    #1;
    chk("start", 32'(sccb_start), 32'd0);
    chk("outs", {24'd0, busy, done, error, sccb_rw, err_index}, 32'd0);
    chk("data", 32'(sccb_data), 32'd0);
    chk("rom_addr", 32'(rom_addr), 32'd0);
    chk("dev_id", 32'(sccb_addr), 32'h78);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      $sformat(tag, "vec%0d", i);
      load_vec(vt[i]);
      model(int'(vt[i].lat), int'(vt[i].hold));
      run_seq(int'(vt[i].lat), int'(vt[i].hold), 1'b0, np);
      chk("tbl_pulses", 32'(np), 32'(vt[i].n));
      chk("tbl_done", 32'(done), 32'(vt[i].done));
      chk("tbl_error", 32'(error), 32'(vt[i].err));
      if (vt[i].err) chk("tbl_eidx", 32'(err_index), 32'(vt[i].eidx));
      repeat (3) @(negedge clk);
    end

    tag = "level";
    load_vec(vt[0]);
    model(2, 0);
    run_seq(2, 0, 1'b1, np);
    repeat (3) @(negedge clk);

    for (int r = 0; r < 8; r++) begin
      int lat, hold, sel;
      $sformat(tag, "rand%0d", r);
      for (int i = 0; i < 16; i++) begin
        sel = int'($urandom_range(0, 11));
        if (sel < 5)      rom_mem[i] = wr(16'($urandom), 8'($urandom));
        else if (sel < 7) rom_mem[i] = vf(16'($urandom), 8'h5A);
        else if (sel < 10) rom_mem[i] = dl(16'($urandom_range(0, 3)));
        else              rom_mem[i] = END_W;
      end
      for (int p = 0; p < NP; p++) begin
        s_ack[p]  = ($urandom_range(0, 4) == 0);
        s_hang[p] = ($urandom_range(0, 40) == 0);
        s_rd[p]   = ($urandom_range(0, 3) != 0) ? 8'h5A : 8'hA5;
      end
      lat  = int'($urandom_range(1, 5));
      hold = int'($urandom_range(0, 3));
      model(lat, hold);
      run_seq(lat, hold, 1'b0, np);
      repeat (3) @(negedge clk);
    end

    tag = "rst_mid";
    load_vec(vt[0]);
    s_hang[0] = 1'b1;
    @(negedge clk); init = 1'b1;
    @(negedge clk); init = 1'b0;
    cnt = 0;
    while (!sccb_start && cnt < 20) begin @(negedge clk); cnt++; end
    chk("start_seen", 32'(sccb_start), 32'd1);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("start", 32'(sccb_start), 32'd0);
    chk("outs", {24'd0, busy, done, error, sccb_rw, err_index}, 32'd0);
    chk("data", 32'(sccb_data), 32'd0);
    chk("rom_addr", 32'(rom_addr), 32'd0);
    chk("dev_id", 32'(sccb_addr), 32'h78);
    @(negedge clk); rst = 1'b1;
    bad = 0;
    repeat (20) begin @(negedge clk); if (sccb_start || busy) bad = 1; end
    chk("no_restart", 32'(bad), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sccb_init_seq.md
Name: sccb_init_seq

Overview:
- Table-driven sequencer for the SCCB controller. It walks a synchronous command ROM of camera register writes, read-verifies and delays after power-up.
- Drives the controller's start/rw/addr/data handshake, checks ack errors and retries failed transactions.
- Reports busy/done/error status to the top-level camera interface.

Parameters:
- DEV_ID, 8'h78, SCCB device ID driven on sccb_addr_o (bit 0 ignored downstream).
- ROM_AW, 10, command ROM address width.
- MAX_RETRY, 3, retries per entry after the first attempt fails.
- DLY_UNIT, 50000, clk_i cycles per delay unit (1 ms at 50 MHz).
- TIMEOUT, 2000000, clk_i cycles allowed per transaction before abort.

Ports:
- clk_i  in  1  main clock
- rst_i  in  1  reset, asynchronous, active-low
- init_start_i  in  1  rising edge starts the sequence
- rom_addr_o  out  ROM_AW  command ROM address
- rom_data_i  in  32  ROM word, valid 1 cycle after rom_addr_o
- sccb_addr_o  out  8  to controller addr_i, constant DEV_ID
- sccb_data_o  out  24  to controller data_i: {reg_addr[15:0], wdata[7:0]}
- sccb_rw_o  out  1  1 = write, 0 = read
- sccb_start_o  out  1  controller start_i
- sccb_done_i  in  1  controller done_o
- sccb_ack_err_i  in  1  controller ack_error_o
- sccb_rdata_i  in  8  controller data_o
- busy_o  out  1  sequence running
- done_o  out  1  sequence completed OK; sticky until next start
- error_o  out  1  sequence aborted; sticky until next start
- err_index_o  out  ROM_AW  ROM index of failing entry

Behaviour:
- ROM word format, opcode = [31:30]:
  - 00 WRITE: reg [23:8], data [7:0].
  - 01 DELAY: count [15:0] units.
  - 10 VERIFY: reg [23:8], expected [7:0], mask [31:24]→ use [29:24] unused; compare full 8 bits.
  - 11 END.
- Reset values: all outputs 0; sccb_addr_o = DEV_ID; state IDLE; retry count, timer and index cleared.
- States: IDLE, FETCH, DECODE, ISSUE, WAIT, RELEASE, DELAY, NEXT, FIN, FAIL.
- IDLE: a 0→1 edge of init_start_i (registered edge detect) clears done_o, error_o, index and retry, sets busy_o, and goes to FETCH. A level held high does not restart.
- FETCH: drive rom_addr_o = index; wait 1 cycle, then DECODE.
- DECODE:
  - END → FIN.
  - DELAY with count 0 → NEXT.
  - DELAY with count >0 → load timer = count*DLY_UNIT-1, go to DELAY.
  - WRITE/VERIFY → latch sccb_data_o, set sccb_rw_o (WRITE = 1, VERIFY = 0), go to ISSUE.
- ISSUE: assert sccb_start_o, clear watchdog, go to WAIT. sccb_data_o and sccb_rw_o stay stable while start is high.
- WAIT: hold start until sccb_done_i = 1.
  - Failure = sccb_ack_err_i = 1, or (VERIFY and sccb_rdata_i != expected); both sampled in the cycle done is seen.
  - Watchdog reaching TIMEOUT-1 also counts as failure.
  - Any exit from WAIT deasserts start → RELEASE.
- RELEASE: keep start low until sccb_done_i = 0, which is mandatory before reissue. Watchdog still applies here; expiry → FAIL directly.
  - Success → NEXT.
  - Failure with retry < MAX_RETRY → retry++, ISSUE.
  - Failure with retry = MAX_RETRY → FAIL.
- DELAY: decrement timer to 0, then NEXT.
- NEXT: index++, retry = 0, → FETCH. Index wrap past 2^ROM_AW-1 without an END entry → FAIL with err_index_o = last index.
- FIN: busy_o = 0, done_o = 1 → IDLE.
- FAIL: busy_o = 0, error_o = 1, err_index_o = index → IDLE.
- init_start_i edge while busy is ignored.
- Async reset mid-transaction drops sccb_start_o immediately; the controller returns to idle on its own.
- Timer width must hold 65535*DLY_UNIT without overflow.

Test Plan:
- ROM {WRITE 0x3008=0x82, END}, slave ACKs → one start pulse, sccb_data_o = 0x300882, rw = 1, then done_o = 1, error_o = 0, busy_o low.
- DELAY 2 with DLY_UNIT = 10 between two WRITEs → gap from done low to next start of 20+overhead cycles, measured exactly against FSM cycle count.
- Ack error on the first 2 attempts, then OK, MAX_RETRY = 3 → 3 start pulses, done_o = 1.
- Ack error persistent → 4 start pulses, error_o = 1, err_index_o = failing index.
- VERIFY 0x300A expect 0x56, rdata 0x56 → pass, rw = 0. With rdata 0x55 → retries then error.
- sccb_done_i never asserted with TIMEOUT = 100 → start drops after 100 cycles, then retries then error. rst_i pulse mid-WAIT → all outputs 0 next cycle, no restart without a new init_start_i edge.
